// File: rtl/pc_seq_pkg.sv
// Shared types and encodings for the PC sequencer: FSM states, branch kinds,
// PC source selects and the next-PC decision helper.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_UPDATE = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  localparam logic [1:0] BR_SEQ = 2'd0;
  localparam logic [1:0] BR_ALU = 2'd1;
  localparam logic [1:0] BR_REG = 2'd2;
  localparam logic [1:0] BR_IMM = 2'd3;

  localparam logic [1:0] CS_ALU  = 2'd0;
  localparam logic [1:0] CS_REG0 = 2'd1;
  localparam logic [1:0] CS_REG1 = 2'd2;
  localparam logic [1:0] CS_IM   = 2'd3;

  localparam logic MODE_INC  = 1'b0;
  localparam logic MODE_LOAD = 1'b1;

  typedef struct packed {
    logic       mode;
    logic [1:0] cs;
  } pc_sel_t;

  // Untaken ALU branches fall back to a plain +4 increment.
  function automatic pc_sel_t decide_next_pc(input logic [1:0] kind, input logic taken);
    pc_sel_t sel;
    sel.mode = MODE_INC;
    sel.cs   = CS_ALU;
    case (kind)
      BR_ALU: sel.mode = taken ? MODE_LOAD : MODE_INC;
      BR_REG: begin
        sel.mode = MODE_LOAD;
        sel.cs   = CS_REG0;
      end
      BR_IMM: begin
        sel.mode = MODE_LOAD;
        sel.cs   = CS_IM;
      end
      default: ;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/pc_seq_timeout.sv
// Instruction-fetch ack watchdog: counts consecutive FETCH cycles without an
// accepted ack and raises a sticky error when the limit is hit.
module pc_seq_timeout #(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_in_fetch,
  input  logic i_ack,
  output logic o_timeout,
  output logic o_fetch_err
);

  localparam logic [3:0] LIMIT = 4'(ACK_TIMEOUT);

  logic [3:0] r_cnt;
  logic       r_fetch_err;

  // Fires in the FETCH cycle that already has LIMIT ack-less cycles behind it.
  assign o_timeout   = i_in_fetch && !i_ack && (r_cnt == LIMIT);
  assign o_fetch_err = r_fetch_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= 4'd0;
      r_fetch_err <= 1'b0;
    end else begin
      if (!i_in_fetch || i_ack) begin
        r_cnt <= 4'd0;
      end else if (r_cnt != LIMIT) begin
        r_cnt <= r_cnt + 4'd1;
      end
      if (o_timeout) begin
        r_fetch_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_seq_ctrl.sv
// Multicycle PC sequencer (IDLE/FETCH/DECODE/UPDATE/HALTED), all outputs registered.
// Optional trap entry through Reg1 is built when PC_SEQ_TRAP_EN is defined.
module pc_seq_ctrl
  import pc_seq_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       imem_req,
  input  logic       imem_ack,
  input  logic       dec_valid,
  input  logic [1:0] br_kind,
  input  logic       br_taken,
  input  logic       halt,
  output logic [1:0] pc_cs,
  output logic       pc_mode,
  output logic       pc_en,
  output logic       busy,
  output logic       halted,
  output logic       fetch_err
`ifdef PC_SEQ_TRAP_EN
  ,
  input  logic       trap_req,
  output logic       trap_ack
`endif
);

  state_t     r_state;
  logic       r_imem_req;
  logic [1:0] r_pc_cs;
  logic       r_pc_mode;
  logic       r_pc_en;
  logic       r_busy;
  logic       r_halted;
`ifdef PC_SEQ_TRAP_EN
  logic       r_trap_ack;
  logic       r_trap_pend;
`endif

  logic    w_in_fetch;
  logic    w_ack;
  logic    w_timeout;
  logic    w_fetch_err;
  pc_sel_t w_sel;

  // An ack only counts as the answer to a request that is actually on the bus.
  assign w_in_fetch = (r_state == ST_FETCH);
  assign w_ack      = w_in_fetch && r_imem_req && imem_ack;
  assign w_sel      = decide_next_pc(br_kind, br_taken);

  pc_seq_timeout #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_timeout (
    .clk        (clk),
    .rst        (rst),
    .i_in_fetch (w_in_fetch),
    .i_ack      (w_ack),
    .o_timeout  (w_timeout),
    .o_fetch_err(w_fetch_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_imem_req <= 1'b0;
      r_pc_cs    <= CS_ALU;
      r_pc_mode  <= MODE_INC;
      r_pc_en    <= 1'b0;
      r_busy     <= 1'b0;
      r_halted   <= 1'b0;
`ifdef PC_SEQ_TRAP_EN
      r_trap_ack  <= 1'b0;
      r_trap_pend <= 1'b0;
`endif
    end else begin
      r_pc_en <= 1'b0;
`ifdef PC_SEQ_TRAP_EN
      r_trap_ack <= 1'b0;
      if (trap_req) begin
        r_trap_pend <= 1'b1;
      end
`endif
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_FETCH;
            r_busy  <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (w_ack) begin
            r_imem_req <= 1'b0;
            r_state    <= ST_DECODE;
          end else if (w_timeout) begin
            r_imem_req <= 1'b0;
            r_busy     <= 1'b0;
            r_halted   <= 1'b1;
            r_state    <= ST_HALTED;
          end else begin
            r_imem_req <= 1'b1;
          end
        end
        ST_DECODE: begin
`ifdef PC_SEQ_TRAP_EN
          if (trap_req || r_trap_pend) begin
            r_trap_pend <= 1'b0;
            r_trap_ack  <= 1'b1;
            r_pc_en     <= 1'b1;
            r_pc_cs     <= CS_REG1;
            r_pc_mode   <= MODE_LOAD;
            r_state     <= ST_UPDATE;
          end else
`endif
          if (dec_valid) begin
            if (halt) begin
              r_busy   <= 1'b0;
              r_halted <= 1'b1;
              r_state  <= ST_HALTED;
            end else begin
              r_pc_en   <= 1'b1;
              r_pc_cs   <= w_sel.cs;
              r_pc_mode <= w_sel.mode;
              r_state   <= ST_UPDATE;
            end
          end
        end
        ST_UPDATE: r_state <= ST_FETCH;
        ST_HALTED: r_state <= ST_HALTED;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  assign imem_req  = r_imem_req;
  assign pc_cs     = r_pc_cs;
  assign pc_mode   = r_pc_mode;
  assign pc_en     = r_pc_en;
  assign busy      = r_busy;
  assign halted    = r_halted;
  assign fetch_err = w_fetch_err;
`ifdef PC_SEQ_TRAP_EN
  assign trap_ack  = r_trap_ack;
`endif

endmodule

// File: doc/pc_seq_ctrl.md
# pc_seq_ctrl

Multicycle sequencer for the CPU program counter. Runs a fetch/decode/update cycle per instruction, handshakes with instruction memory, and drives the PC counter's source select (`pc_cs`), load/increment mode (`pc_mode`) and enable (`pc_en`). It sits between the decoder/branch unit and the PC counter block, and is the only agent allowed to advance the PC.

## Interface

Parameters:
- `ACK_TIMEOUT`, default 15: maximum `imem_ack` wait cycles before `fetch_err` is flagged; 4-bit counter.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  level; leaves IDLE when high.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_ack`  in  1  fetch complete; instruction valid this cycle.
- `dec_valid`  in  1  decoder has resolved the next-PC kind for the current instruction.
- `br_kind`  in  2  0 = sequential, 1 = ALU target, 2 = register jump, 3 = immediate jump.
- `br_taken`  in  1  qualifies `br_kind` = 1; ignored for other kinds.
- `halt`  in  1  sampled with `dec_valid`; stops sequencing.
- `pc_cs`  out  2  PC source select: 0 ALU, 1 Reg0, 2 Reg1, 3 IM.
- `pc_mode`  out  1  0 = increment by 4, 1 = load selected source.
- `pc_en`  out  1  one-cycle PC update strobe.
- `busy`  out  1  high in any state except IDLE and HALTED.
- `halted`  out  1  high in HALTED.
- `fetch_err`  out  1  sticky; set on ack timeout.
- `trap_req` / `trap_ack`  in / out  1  present only with `PC_SEQ_TRAP_EN` (see Configuration).

## Operation

- States: IDLE, FETCH, DECODE, UPDATE, HALTED.
- IDLE: all outputs 0. `start` = 1 moves to FETCH.
- FETCH: `imem_req` = 1. `imem_ack` moves to DECODE and clears the timeout counter. When the counter reaches `ACK_TIMEOUT`, `fetch_err` is set and the FSM goes to HALTED.
- DECODE: waits for `dec_valid`.
  - `halt` = 1 moves to HALTED with no PC update.
  - Otherwise the next-PC decision is latched and the FSM moves to UPDATE.
- Next-PC decision:
  - sequential, or ALU target with `br_taken` = 0: `pc_mode` = 0, `pc_cs` = 0.
  - ALU target with `br_taken` = 1: `pc_mode` = 1, `pc_cs` = 0.
  - register jump: `pc_mode` = 1, `pc_cs` = 1.
  - immediate jump: `pc_mode` = 1, `pc_cs` = 3.
- UPDATE: `pc_en` = 1 for exactly one cycle with the latched `pc_cs`/`pc_mode`, then FETCH.
- HALTED: absorbing; only `rst` leaves it.
- `pc_cs` and `pc_mode` hold their last value outside UPDATE. `pc_en` is 0 outside UPDATE.
- Inputs not listed for a state are ignored in that state.

## Timing

- All outputs registered.
- Reset values: state IDLE, `imem_req`/`pc_en`/`busy`/`halted`/`fetch_err`/`trap_ack` = 0, `pc_cs` = 0, `pc_mode` = 0.
- Minimum instruction period is 4 cycles: FETCH (ack in first cycle), DECODE (`dec_valid` in first cycle), UPDATE, then back to FETCH. Each extra wait cycle adds one.
- `imem_req` rises the cycle after entering FETCH and falls the cycle after `imem_ack`.
- `pc_en` is high in the cycle after `dec_valid` is sampled.
- `imem_ack` arriving while not in FETCH is ignored.
- `rst` mid-instruction, including during UPDATE, aborts with no further `pc_en`. The outputs take their reset values on the next edge.
- Timeout: with `ACK_TIMEOUT` = 15, `fetch_err` rises in the 16th consecutive FETCH cycle without ack.

## Configuration

- Macro: `PC_SEQ_TRAP_EN`.
- Defined:
  - `trap_req`/`trap_ack` ports exist. `trap_req` is sampled in DECODE and has priority over `dec_valid`/`halt`.
  - A trap forces UPDATE with `pc_mode` = 1, `pc_cs` = 2; Reg1 carries the vector.
  - `trap_ack` pulses together with that `pc_en`.
  - `trap_req` in other states is held pending until DECODE.
- Undefined: no trap ports and no trap logic; behaviour otherwise identical.

## Structure

- Shared package `pc_seq_pkg`:
  - state enum.
  - `br_kind` encodings (`BR_SEQ`, `BR_ALU`, `BR_REG`, `BR_IMM`).
  - `pc_cs` encodings (`CS_ALU`, `CS_REG0`, `CS_REG1`, `CS_IM`).
  - Mode constants (`MODE_INC`, `MODE_LOAD`).
- One sub-module: `pc_seq_timeout`, the ack-timeout counter and sticky error flag.
- The FSM and next-PC latch stay in `pc_seq_ctrl`.

## Test plan

- Reset then `start`; ack and `dec_valid` in the first cycle with `br_kind` = 0 -> `pc_en` every 4th cycle with `pc_mode` = 0, `pc_cs` = 0.
- `br_kind` = 1: `br_taken` = 1 -> UPDATE with `pc_mode` = 1, `pc_cs` = 0; `br_taken` = 0 -> `pc_mode` = 0. Then `br_kind` = 3 -> `pc_cs` = 3, `pc_mode` = 1.
- `imem_ack` delayed 5 cycles -> `imem_req` high for 6 cycles and a 9-cycle instruction period; no ack for 16 cycles -> `fetch_err` = 1, `halted` = 1, no `pc_en`.
- `halt` = 1 with `dec_valid` -> `halted` = 1 and no `pc_en`; later `start` toggles are ignored; `rst` -> IDLE.
- `rst` asserted in the UPDATE cycle -> `pc_en` = 0 on the next edge and all outputs at reset values.
- With `PC_SEQ_TRAP_EN`: `trap_req` and `dec_valid` in the same DECODE cycle -> `pc_cs` = 2, `pc_mode` = 1, `trap_ack` coincident with `pc_en`.
